// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Single-clock word memory (DEPTH = 2**DEPTH_LOG2 x 16 bits) serving a core
//   through two ports. The instruction port is read-only. The data port can
//   read and write. After reset the block sweeps every word to zero (CLEAR),
//   then serves accesses (RUN).
//
//   Both read ports are registered. An address presented before a rising edge
//   is captured on that edge, and its word appears on the output just after
//   that edge. Reads are write-first: a read of the word being stored on the
//   same edge returns the new store data.
//
//   Addresses with any bit set above the memory range are out of range. Such
//   a read returns zero and such a write is dropped. Each out-of-range port in
//   a RUN cycle adds one to a saturating 8-bit counter.
//
// Ports
//   clk                           rising-edge clock
//   rst_n                         asynchronous active-low reset
//   address_from_instruction_port instruction-fetch word address
//   data_to_instruction_port      instruction word (registered)
//   address_from_core             data-access word address
//   data_from_core                store data
//   write_en_from_core            store strobe
//   data_to_core                  load data (registered)
//   ready                         high once the CLEAR sweep has finished
//   out_of_range_count            saturating count of out-of-range accesses
module main_memory_responder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address_from_instruction_port,
  output logic [15:0] data_to_instruction_port,
  input  logic [15:0] address_from_core,
  input  logic [15:0] data_from_core,
  input  logic        write_en_from_core,
  output logic [15:0] data_to_core,
  output logic        ready,
  output logic [7:0]  out_of_range_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            state;
  logic [DEPTH_LOG2-1:0] clear_ptr;
  logic [15:0]           mem [DEPTH];

  // An address is valid only when every bit above the index field is zero,
  // so out-of-range accesses never alias onto a real word.
  function automatic logic in_range(input logic [15:0] a);
    return (a >> DEPTH_LOG2) == 16'h0000;
  endfunction

  // Add 0..2 to the counter, clamping at all-ones instead of wrapping.
  function automatic logic [7:0] sat_add_cnt(input logic [7:0] c,
                                             input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, c} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic                  instr_ok;
  logic                  core_ok;
  logic                  wr_fire;
  logic [DEPTH_LOG2-1:0] instr_idx;
  logic [DEPTH_LOG2-1:0] core_idx;
  logic [1:0]            oor_inc;
  logic [15:0]           instr_rd_nxt;
  logic [15:0]           core_rd_nxt;

  assign instr_ok  = in_range(address_from_instruction_port);
  assign core_ok   = in_range(address_from_core);
  assign instr_idx = address_from_instruction_port[DEPTH_LOG2-1:0];
  assign core_idx  = address_from_core[DEPTH_LOG2-1:0];
  assign wr_fire   = (state == ST_RUN) && write_en_from_core && core_ok;
  assign oor_inc   = {1'b0, ~instr_ok} + {1'b0, ~core_ok};

  // Read-data selection ahead of the output registers. A store on this edge
  // bypasses the array so both ports see the new data (write-first).
  always_comb begin
    instr_rd_nxt = 16'h0000;
    core_rd_nxt  = 16'h0000;
    if (state == ST_RUN) begin
      if (instr_ok) begin
        if (wr_fire && (address_from_instruction_port == address_from_core))
          instr_rd_nxt = data_from_core;
        else
          instr_rd_nxt = mem[instr_idx];
      end
      if (core_ok) begin
        if (wr_fire)
          core_rd_nxt = data_from_core;
        else
          core_rd_nxt = mem[core_idx];
      end
    end
  end

  // Storage array: no reset on the contents. Writes are suppressed while
  // rst_n is low, so a store in flight when reset hits is discarded. The
  // CLEAR sweep is the only thing that zeroes the array.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR)
        mem[clear_ptr] <= 16'h0000;
      else if (wr_fire)
        mem[core_idx] <= data_from_core;
    end
  end

  // Control, output registers and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= ST_CLEAR;
      clear_ptr                <= '0;
      ready                    <= 1'b0;
      data_to_core             <= 16'h0000;
      data_to_instruction_port <= 16'h0000;
      out_of_range_count       <= 8'h00;
    end else begin
      data_to_core             <= core_rd_nxt;
      data_to_instruction_port <= instr_rd_nxt;
      case (state)
        ST_CLEAR: begin
          clear_ptr <= clear_ptr + DEPTH_LOG2'(1);
          // The edge that zeroes the last word also opens the memory for use.
          if (clear_ptr == {DEPTH_LOG2{1'b1}}) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          out_of_range_count <= sat_add_cnt(out_of_range_count, oor_inc);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] ai = 16'h0000;
  logic [15:0] ac = 16'h0000;
  logic [15:0] dc = 16'h0000;
  logic        we = 1'b0;
  logic [15:0] di;
  logic [15:0] dcore;
  logic        rdy;
  logic [7:0]  cnt;

  int checks = 0;
  int passes = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  main_memory_responder #(.DEPTH_LOG2(8)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .address_from_instruction_port(ai),
    .data_to_instruction_port     (di),
    .address_from_core            (ac),
    .data_from_core               (dc),
    .write_en_from_core           (we),
    .data_to_core                 (dcore),
    .ready                        (rdy),
    .out_of_range_count           (cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset with no clock edge involved.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_dcore", dcore, 16'h0000);
    chk("rst_di", di, 16'h0000);
    chk("rst_ready", 16'(rdy), 16'h0000);
    chk("rst_cnt", 16'(cnt), 16'h0000);

    // Core tries to store and an out-of-range fetch is presented for the
    // whole CLEAR phase; both must be ignored.
    ac = 16'h0005; dc = 16'hFFFF; we = 1'b1; ai = 16'h0400;
    cyc;
    cyc;
    chk("rst_hold_ready", 16'(rdy), 16'h0000);
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      cyc;
      chk("clear_ready", 16'(rdy), 16'(i == 256));
      if (i == 128) begin
        chk("clear_dcore", dcore, 16'h0000);
        chk("clear_di", di, 16'h0000);
        chk("clear_cnt", 16'(cnt), 16'h0000);
      end
    end
    chk("clear_end_cnt", 16'(cnt), 16'h0000);

    // First RUN read: word 5 was cleared, not overwritten by the core.
    we = 1'b0; ai = 16'h0000; ac = 16'h0005;
    cyc;
    chk("run_rd5", dcore, 16'h0000);
    chk("run_rd0_instr", di, 16'h0000);

    // Store then load.
    ac = 16'h0010; dc = 16'hBEEF; we = 1'b1;
    cyc;
    chk("wr_first_core", dcore, 16'hBEEF);
    we = 1'b0; dc = 16'h0000;
    cyc;
    chk("rd10_t1", dcore, 16'hBEEF);
    cyc;
    chk("rd10_t2", dcore, 16'hBEEF);
    // Output must not follow the address combinationally.
    ac = 16'h0011;
    #1;
    chk("rd_registered", dcore, 16'hBEEF);
    cyc;
    chk("rd11", dcore, 16'h0000);

    // Write-first on both ports at once.
    ac = 16'h0020; dc = 16'h1234; we = 1'b1; ai = 16'h0020;
    cyc;
    chk("wf_core", dcore, 16'h1234);
    chk("wf_instr", di, 16'h1234);
    we = 1'b0; dc = 16'h0000;
    cyc;
    chk("rd20_core", dcore, 16'h1234);
    chk("rd20_instr", di, 16'h1234);

    // Highest in-range word.
    ac = 16'h00FF; dc = 16'hCAFE; we = 1'b1; ai = 16'h00FF;
    cyc;
    chk("wf_ff_instr", di, 16'hCAFE);
    chk("inrange_cnt", 16'(cnt), 16'h0000);

    // Out-of-range fetch alongside an in-range store.
    ac = 16'h0000; dc = 16'h5A5A; we = 1'b1; ai = 16'h0100;
    cyc;
    chk("oor_instr_cnt", 16'(cnt), 16'h0001);
    chk("oor_instr_rd", di, 16'h0000);

    // Out-of-range store of 0xAAAA to 0x0100 must not alias onto word 0.
    ac = 16'h0100; dc = 16'hAAAA; we = 1'b1; ai = 16'h0000;
    cyc;
    chk("oor_wr_cnt", 16'(cnt), 16'h0002);
    chk("oor_wr_dcore", dcore, 16'h0000);
    chk("oor_wr_instr_w0", di, 16'h5A5A);
    we = 1'b0; ac = 16'h0000; ai = 16'h0000;
    cyc;
    chk("w0_core", dcore, 16'h5A5A);
    chk("w0_instr", di, 16'h5A5A);
    chk("w0_cnt", 16'(cnt), 16'h0002);

    // Both ports out of range: +2 per cycle up to saturation.
    exp_cnt = 2;
    ac = 16'h0200; ai = 16'h0200;
    for (int i = 1; i <= 200; i++) begin
      cyc;
      exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
      chk("sat_cnt", 16'(cnt), 16'(exp_cnt));
    end

    // Store to 0xFFFF is dropped; word 0xFF keeps its data.
    ac = 16'hFFFF; dc = 16'h1111; we = 1'b1; ai = 16'h0010;
    cyc;
    chk("sat_hold", 16'(cnt), 16'h00FF);
    chk("rd10_instr", di, 16'hBEEF);
    we = 1'b0; ai = 16'h00FF;
    cyc;
    chk("ff_not_aliased", di, 16'hCAFE);

    // Mid-run reset with a store pending.
    ac = 16'h0010; ai = 16'h0020;
    cyc;
    chk("pre_rst_dcore", dcore, 16'hBEEF);
    ac = 16'h0030; dc = 16'h7777; we = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dcore", dcore, 16'h0000);
    chk("mid_rst_di", di, 16'h0000);
    chk("mid_rst_ready", 16'(rdy), 16'h0000);
    chk("mid_rst_cnt", 16'(cnt), 16'h0000);
    cyc;
    cyc;
    rst_n = 1'b1;
    we = 1'b0; ac = 16'h0010; ai = 16'h0030;
    for (int i = 1; i <= 256; i++) begin
      cyc;
      chk("reclear_ready", 16'(rdy), 16'(i == 256));
    end
    cyc;
    chk("reclear_rd10", dcore, 16'h0000);
    chk("reclear_rd30", di, 16'h0000);
    chk("reclear_cnt", 16'(cnt), 16'h0000);

    // Memory is writable again after the second sweep.
    ac = 16'h0010; dc = 16'h4321; we = 1'b1;
    cyc;
    we = 1'b0;
    cyc;
    chk("post_rst_wr", dcore, 16'h4321);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
